seg7_scan_driver: RTL and testbench
===================================

SEG7_SCAN_DRIVER -- requirements
Module: seg7_scan_driver

Interface
REQ-001 The block SHALL have parameter NDIGITS, default 4, number of multiplexed digits (legal 1..8).
REQ-002 The block SHALL have parameter DIV, default 50000, clock cycles per digit slot (legal >= 4).
REQ-003 The block SHALL have parameter DEAD, default 2, leading cycles of each slot with all digits off (legal 0..DIV-2).
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 value  input  4*NDIGITS  hex nibbles; nibble k (bits 4k+3:4k) drives digit k, digit 0 least significant.
REQ-007 load  input  1  when high, value is captured into the pending register.
REQ-008 seg  output  7  active-low segments, bit0=a to bit6=g, registered.
REQ-009 an  output  NDIGITS  active-low digit enables, one-hot-low or all-high, registered.
REQ-010 frame  output  1  one-cycle pulse at the start of each scan frame.

Function
REQ-011 Prescaler cnt SHALL count 0..DIV-1 and wrap to 0; slot end = cycle with cnt==DIV-1.
REQ-012 Digit index idx SHALL increment at each slot end, wrapping NDIGITS-1 -> 0.
REQ-013 load=1 SHALL copy value into the pending register and set pend; load while pend=1 SHALL overwrite the pending data.
REQ-014 The display register SHALL take pending data only at a slot end where idx wraps to 0, clearing pend; a frame never shows mixed old/new digits.
REQ-015 load coinciding with the transfer cycle SHALL take priority: new data goes to pending, pend stays 1, previous pending data is transferred.
REQ-016 frame SHALL be 1 in the cycle after idx wraps to 0, else 0.
REQ-017 While cnt<DEAD, an SHALL be all ones and seg 7'b1111111.
REQ-018 While cnt>=DEAD, an[idx]=0 and all other bits 1; seg SHALL be the code of display nibble idx, one cycle after cnt/idx (registered).
REQ-019 Codes (hex -> seg g..a): 0 1000000, 1 1111001, 2 0100100, 3 0110000, 4 0011001, 5 0010010, 6 0000010, 7 1111000, 8 0000000, 9 0010000, A 0001000, b 0000011, C 1000110, d 0100001, E 0000110, F 0001110.
REQ-020 With NDIGITS=1, idx SHALL stay 0 and frame SHALL pulse at every slot end.

Reset
REQ-021 reset SHALL force cnt=0, idx=0, display=0, pending=0, pend=0, an all ones, seg=7'b1111111, frame=0 on the next edge.
REQ-022 reset SHALL override load in the same cycle; the first frame pulse follows exactly NDIGITS*DIV cycles after reset deassertion.
REQ-023 reset asserted mid-slot SHALL abort the scan and discard any pending data.

Configuration
REQ-024 Macro SEG7_LZ_SUPPRESS_EN: when defined, any digit k>0 whose nibble and all higher nibbles are 0 SHALL show seg=7'b1111111 with its an still scanned; digit 0 always shown.
REQ-025 Without SEG7_LZ_SUPPRESS_EN, all digits SHALL display their code, including leading zeros.

Verification (NDIGITS=4, DIV=4, DEAD=1)
REQ-026 Reset, then run 16 cycles -> all digits show 1000000 in order an=1110,1101,1011,0111, an=1111 on each cnt=0 cycle; frame high at cycle 16.
REQ-027 load value=16'h12AF mid-frame -> display unchanged until next frame; then digit0 0001110, digit1 0001000, digit2 0100100, digit3 1111001.
REQ-028 Two loads (16'h1111 then 16'h2222) within one frame -> only 2222 displayed next frame; 1111 never visible.
REQ-029 load 16'h3333 on the idx-wrap cycle with pending 16'h4444 -> frame shows 4444, following frame shows 3333.
REQ-030 reset asserted at cnt=2, idx=2 with pend=1 -> next cycle an=1111, seg=1111111, frame=0; pending data never displayed.
REQ-031 With SEG7_LZ_SUPPRESS_EN, value=16'h0050 -> digits 3,2 seg=1111111, digit1 0010010, digit0 1000000; value=0 -> only digit0 lit.

Source files
------------

// File: rtl/seg7_scan_driver.sv
// seg7_scan_driver: multiplexed 7-segment scanner; define SEG7_LZ_SUPPRESS_EN to blank leading zeros
module seg7_scan_driver #(
    parameter int NDIGITS = 4,
    parameter int DIV     = 50000,
    parameter int DEAD    = 2
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [4*NDIGITS-1:0]   value,
    input  logic                   load,
    output logic [6:0]             seg,
    output logic [NDIGITS-1:0]     an,
    output logic                   frame
);
    localparam int CW = $clog2(DIV);
    localparam int IW = NDIGITS > 1 ? $clog2(NDIGITS) : 1;
    localparam int W  = 4 * NDIGITS;

    logic [CW-1:0]      cnt_q, cnt_d;
    logic [IW-1:0]      idx_q, idx_d;
    logic [W-1:0]       disp_q, disp_d, pdata_q, pdata_d;
    logic               pend_q, pend_d, frame_q, frame_d;
    logic [6:0]         seg_q, seg_d;
    logic [NDIGITS-1:0] an_q, an_d;
    logic               slot_end, wrap, dead, blank;
    logic [3:0]         nib;

    function automatic logic [6:0] hex7(input logic [3:0] h);
        case (h)
            4'h0: hex7 = 7'b1000000;
            4'h1: hex7 = 7'b1111001;
            4'h2: hex7 = 7'b0100100;
            4'h3: hex7 = 7'b0110000;
            4'h4: hex7 = 7'b0011001;
            4'h5: hex7 = 7'b0010010;
            4'h6: hex7 = 7'b0000010;
            4'h7: hex7 = 7'b1111000;
            4'h8: hex7 = 7'b0000000;
            4'h9: hex7 = 7'b0010000;
            4'ha: hex7 = 7'b0001000;
            4'hb: hex7 = 7'b0000011;
            4'hc: hex7 = 7'b1000110;
            4'hd: hex7 = 7'b0100001;
            4'he: hex7 = 7'b0000110;
            default: hex7 = 7'b0001110;
        endcase
    endfunction

    always_comb begin
        slot_end = cnt_q == CW'(DIV - 1);
        wrap     = slot_end && idx_q == IW'(NDIGITS - 1);
        cnt_d    = slot_end ? '0 : cnt_q + 1'b1;
        idx_d    = wrap ? '0 : idx_q + IW'(slot_end);
        // a load on the transfer cycle lands in pending while the old pending moves to display
        pdata_d  = load ? value : pdata_q;
        pend_d   = load | (pend_q & ~wrap);
        disp_d   = (wrap && pend_q) ? pdata_q : disp_q;
        frame_d  = wrap;
        nib      = disp_q[4*idx_q +: 4];
`ifdef SEG7_LZ_SUPPRESS_EN
        blank    = idx_q != '0 && (disp_q >> (4*idx_q)) == '0;
`else
        blank    = 1'b0;
`endif
        dead     = cnt_q < CW'(DEAD);
        an_d     = dead ? '1 : ~(NDIGITS'(1) << idx_q);
        seg_d    = (dead || blank) ? 7'h7f : hex7(nib);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q   <= '0;
            idx_q   <= '0;
            disp_q  <= '0;
            pdata_q <= '0;
            pend_q  <= 1'b0;
            frame_q <= 1'b0;
            seg_q   <= 7'h7f;
            an_q    <= '1;
        end else begin
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            disp_q  <= disp_d;
            pdata_q <= pdata_d;
            pend_q  <= pend_d;
            frame_q <= frame_d;
            seg_q   <= seg_d;
            an_q    <= an_d;
        end
    end

    assign seg   = seg_q;
    assign an    = an_q;
    assign frame = frame_q;
endmodule

// File: tb/tb_seg7_scan_driver.sv
// tb_seg7_scan_driver: directed checks of scan order, frame-synchronous loads and reset (NDIGITS=4, DIV=4, DEAD=1)
module tb_seg7_scan_driver;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [15:0] value = '0;
    logic        load = 1'b0;
    logic [6:0]  seg;
    logic [3:0]  an;
    logic        frame;
    int          checks = 0;
    int          failures = 0;
    logic [6:0]  codes [16] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                                7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                                7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
                                7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};

    seg7_scan_driver #(.NDIGITS(4), .DIV(4), .DEAD(1)) dut (
        .clk(clk), .reset(reset), .value(value), .load(load),
        .seg(seg), .an(an), .frame(frame)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One full frame starting at cnt=0/idx=0; step j covers the cycle with cnt=j%4, idx=j/4,
    // whose registered outputs appear after that cycle's closing edge.
    task automatic run_frame(input int fr, input logic [15:0] d,
                             input int s1, input logic [15:0] v1,
                             input int s2, input logic [15:0] v2);
        logic [3:0] nib;
        logic [6:0] es;
        logic [3:0] ea;
        int k;
        for (int j = 0; j < 16; j++) begin
            load  = (j == s1) || (j == s2);
            value = (j == s2) ? v2 : (j == s1) ? v1 : 16'h0;
            tick();
            load = 1'b0;
            k   = j / 4;
            nib = d[4*k +: 4];
            es  = codes[nib];
`ifdef SEG7_LZ_SUPPRESS_EN
            if (k > 0 && (d >> (4*k)) == 16'h0) es = 7'h7f;
`endif
            ea = ~(4'b0001 << k);
            if (j % 4 == 0) begin
                es = 7'h7f;
                ea = 4'hf;
            end
            chk($sformatf("f%0d_j%0d_an", fr, j), 32'(an), 32'(ea));
            chk($sformatf("f%0d_j%0d_seg", fr, j), 32'(seg), 32'(es));
            chk($sformatf("f%0d_j%0d_frame", fr, j), 32'(frame), 32'(j == 15));
        end
    endtask

    initial begin
        load  = 1'b1;
        value = 16'hffff;
        repeat (3) tick();
        chk("rst_an", 32'(an), 32'hf);
        chk("rst_seg", 32'(seg), 32'h7f);
        chk("rst_frame", 32'(frame), 32'h0);
        load  = 1'b0;
        value = 16'h0;
        reset = 1'b0;
        run_frame(1, 16'h0000, -1, 16'h0, -1, 16'h0);
        run_frame(2, 16'h0000, 6, 16'h12af, -1, 16'h0);
        run_frame(3, 16'h12af, -1, 16'h0, -1, 16'h0);
        run_frame(4, 16'h12af, 2, 16'h1111, 9, 16'h2222);
        run_frame(5, 16'h2222, -1, 16'h0, -1, 16'h0);
        run_frame(6, 16'h2222, 5, 16'h4444, 15, 16'h3333);
        run_frame(7, 16'h4444, -1, 16'h0, -1, 16'h0);
        run_frame(8, 16'h3333, -1, 16'h0, -1, 16'h0);
        run_frame(9, 16'h3333, 0, 16'h5555, -1, 16'h0);
        run_frame(10, 16'h5555, -1, 16'h0, -1, 16'h0);
        run_frame(11, 16'h5555, 1, 16'h0050, -1, 16'h0);
        run_frame(12, 16'h0050, -1, 16'h0, -1, 16'h0);
        // leave pend=1 and stop at cnt=2, idx=2, then reset mid-slot
        load  = 1'b1;
        value = 16'h6789;
        tick();
        load  = 1'b0;
        value = 16'h0;
        repeat (9) tick();
        reset = 1'b1;
        tick();
        chk("midrst_an", 32'(an), 32'hf);
        chk("midrst_seg", 32'(seg), 32'h7f);
        chk("midrst_frame", 32'(frame), 32'h0);
        reset = 1'b0;
        run_frame(13, 16'h0000, -1, 16'h0, -1, 16'h0);
        run_frame(14, 16'h0000, -1, 16'h0, -1, 16'h0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
